// File: rtl/arb_param_core_if.sv
// Arbiter request/grant bus: requests, mask and configuration in, registered grant out.
//   req      NUM_REQ            request vector, bit i = requester i
//   req_mask NUM_REQ            1 = requester blocked
//   arb_mode 2                  0 fixed-prio, 1 round-robin, 2 weighted RR, 3 disabled
//   prio_top IDX_W              highest-priority index in fixed-priority mode
//   weights  NUM_REQ*WEIGHT_W   field i = WRR weight of requester i
//   gnt      NUM_REQ            one-hot grant
//   gnt_vld  1                  grant present
//   gnt_idx  IDX_W              binary index of the granted requester
interface arb_param_core_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WEIGHT_W = 3
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          req_mask;
    logic [1:0]                  arb_mode;
    logic [IDX_W-1:0]            prio_top;
    logic [NUM_REQ*WEIGHT_W-1:0] weights;
    logic [NUM_REQ-1:0]          gnt;
    logic                        gnt_vld;
    logic [IDX_W-1:0]            gnt_idx;

    // Requester / config side
    modport master (
        output req, req_mask, arb_mode, prio_top, weights,
        input  gnt, gnt_vld, gnt_idx
    );

    // Arbiter side
    modport slave (
        input  req, req_mask, arb_mode, prio_top, weights,
        output gnt, gnt_vld, gnt_idx
    );
endinterface

// File: rtl/arb_param_core.sv
// Parametrised N-way arbiter: fixed priority with programmable top, round-robin,
// weighted round-robin and disabled modes, with per-requester masking.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  arb_param_core_if.slave: req/req_mask/arb_mode/prio_top/weights in,
//        registered gnt/gnt_vld/gnt_idx out (one arbitration per cycle)
module arb_param_core #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WEIGHT_W = 3
) (
    input logic             clk,
    input logic             rst,
    arb_param_core_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_RR    = 2'd1;
    localparam logic [1:0] MODE_WRR   = 2'd2;

    logic [NUM_REQ-1:0]  eff_req;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d, credit_eff;
    logic [1:0]          mode_q;
    logic [NUM_REQ-1:0]  gnt_d;
    logic [IDX_W-1:0]    idx_d;
    logic [IDX_W-1:0]    top;
    logic [IDX_W:0]      fx_hit, rr_hit;
    logic [WEIGHT_W-1:0] wgt [NUM_REQ];

    // First set bit of r at or after start, wrapping; MSB of result = found
    function automatic logic [IDX_W:0] search(input logic [NUM_REQ-1:0] r,
                                              input logic [IDX_W-1:0]   start);
        logic [IDX_W:0] res;
        int unsigned    p;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            p = 32'(start) + k;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (!res[IDX_W] && r[IDX_W'(p)]) res = {1'b1, IDX_W'(p)};
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (32'(i) == NUM_REQ - 1) return '0;
        return i + IDX_W'(1);
    endfunction

    assign eff_req = bus.req & ~bus.req_mask;
    assign top     = (32'(bus.prio_top) >= NUM_REQ) ? '0 : bus.prio_top;
    assign fx_hit  = search(eff_req, top);
    assign rr_hit  = search(eff_req, rr_ptr_q);

    // Unpack weight fields; a zero weight behaves as one
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            wgt[k] = bus.weights[k*WEIGHT_W +: WEIGHT_W];
            if (wgt[k] == '0) wgt[k] = WEIGHT_W'(1);
        end
    end

    // Next grant and arbitration state
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        credit_d   = credit_q;
        gnt_d      = '0;
        idx_d      = '0;
        // Any mode change forfeits outstanding WRR credit
        credit_eff = (bus.arb_mode != mode_q) ? '0 : credit_q;
        credit_d   = credit_eff;

        case (bus.arb_mode)
            MODE_FIXED: begin
                if (fx_hit[IDX_W]) begin
                    idx_d = fx_hit[IDX_W-1:0];
                    gnt_d = NUM_REQ'(1) << idx_d;
                end
            end
            MODE_RR: begin
                if (rr_hit[IDX_W]) begin
                    idx_d    = rr_hit[IDX_W-1:0];
                    gnt_d    = NUM_REQ'(1) << idx_d;
                    rr_ptr_d = next_idx(idx_d);
                end
            end
            MODE_WRR: begin
                if (credit_eff != '0 && eff_req[owner_q]) begin
                    idx_d    = owner_q;
                    gnt_d    = NUM_REQ'(1) << idx_d;
                    credit_d = credit_eff - WEIGHT_W'(1);
                end else if (rr_hit[IDX_W]) begin
                    // Owner gone or credit spent: re-arbitrate in the same cycle
                    idx_d    = rr_hit[IDX_W-1:0];
                    gnt_d    = NUM_REQ'(1) << idx_d;
                    credit_d = wgt[idx_d] - WEIGHT_W'(1);
                    owner_d  = idx_d;
                    rr_ptr_d = next_idx(idx_d);
                end
            end
            default: begin
                credit_d = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            credit_q    <= '0;
            mode_q      <= '0;
            bus.gnt     <= '0;
            bus.gnt_vld <= 1'b0;
            bus.gnt_idx <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            credit_q    <= credit_d;
            mode_q      <= bus.arb_mode;
            bus.gnt     <= gnt_d;
            bus.gnt_vld <= |gnt_d;
            bus.gnt_idx <= idx_d;
        end
    end
endmodule

// File: tb/tb_arb_param_core.sv
// Self-checking bench for arb_param_core (NUM_REQ=4, WEIGHT_W=3): directed
// sequences with literal expectations, a reference model checked every cycle,
// and a pseudo-random soak.
module tb_arb_param_core;
    localparam int N = 4;
    localparam int W = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    arb_param_core_if #(.NUM_REQ(N), .WEIGHT_W(W)) bus ();

    arb_param_core #(.NUM_REQ(N), .WEIGHT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_ptr, m_credit, m_owner, m_pmode;
    logic [3:0] exp_gnt;
    int         exp_idx;
    bit         model_ok;

    function automatic int first_from(input logic [3:0] e, input int s);
        for (int k = 0; k < N; k++) begin
            if (e[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    function automatic int weight_of(input logic [11:0] wv, input int i);
        int w;
        w = int'((wv >> (i * W)) & 12'h7);
        return (w == 0) ? 1 : w;
    endfunction

    always @(posedge clk) begin
        logic [3:0] e;
        int         win;
        int         mode;
        if (rst) begin
            m_ptr = 0; m_credit = 0; m_owner = 0; m_pmode = 0;
            exp_gnt = '0; exp_idx = 0; model_ok = 1'b1;
        end else begin
            e    = bus.req & ~bus.req_mask;
            mode = int'(bus.arb_mode);
            if (mode != m_pmode) m_credit = 0;
            m_pmode = mode;
            win = -1;
            if (mode == 0) begin
                win = first_from(e, (int'(bus.prio_top) < N) ? int'(bus.prio_top) : 0);
            end else if (mode == 1) begin
                win = first_from(e, m_ptr);
                if (win >= 0) m_ptr = (win + 1) % N;
            end else if (mode == 2) begin
                if (m_credit > 0 && e[m_owner]) begin
                    win = m_owner;
                    m_credit--;
                end else begin
                    win = first_from(e, m_ptr);
                    if (win >= 0) begin
                        m_credit = weight_of(bus.weights, win) - 1;
                        m_owner  = win;
                        m_ptr    = (win + 1) % N;
                    end
                end
            end else begin
                m_credit = 0;
            end
            exp_gnt = (win >= 0) ? 4'(1 << win) : 4'b0000;
            exp_idx = (win >= 0) ? win : 0;
        end
    end

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            checks++;
            if (bus.gnt !== exp_gnt || bus.gnt_vld !== (exp_gnt != 0) ||
                int'(bus.gnt_idx) != exp_idx) begin
                failures++;
                $display("FAIL model_cmp t=%0t: gnt=%b vld=%b idx=%0d, expected gnt=%b vld=%b idx=%0d",
                         $time, bus.gnt, bus.gnt_vld, bus.gnt_idx, exp_gnt, exp_gnt != 0, exp_idx);
            end
        end
    end

    // Structural properties of the grant
    always @(posedge clk) begin
        #1;
        if (model_ok && !$onehot0(bus.gnt)) begin
            failures++;
            $display("FAIL onehot t=%0t: gnt=%b", $time, bus.gnt);
        end
    end

    logic [3:0] prev_eff;
    always @(posedge clk) begin
        #1;
        if (model_ok && !rst && ((bus.gnt & ~prev_eff) != 0)) begin
            failures++;
            $display("FAIL gnt_without_req t=%0t: gnt=%b prev_eff=%b", $time, bus.gnt, prev_eff);
        end
    end
    always @(posedge clk) prev_eff <= bus.req & ~bus.req_mask;

    // ---------------- stimulus helpers ----------------
    task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] mk,
                         input logic [1:0] md, input logic [1:0] tp, input logic [11:0] wv);
        @(negedge clk);
        rst = r; bus.req = rq; bus.req_mask = mk; bus.arb_mode = md;
        bus.prio_top = tp; bus.weights = wv;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic [3:0] eg);
        int ei;
        ei = 0;
        for (int k = 0; k < N; k++) if (eg[k]) ei = k;
        checks++;
        if (bus.gnt !== eg || bus.gnt_vld !== (eg != 0) || int'(bus.gnt_idx) != ei) begin
            failures++;
            $display("FAIL %s: gnt=%b vld=%b idx=%0d, expected gnt=%b vld=%b idx=%0d",
                     nm, bus.gnt, bus.gnt_vld, bus.gnt_idx, eg, eg != 0, ei);
        end
        checks++;
        if (exp_gnt !== eg) begin
            failures++;
            $display("FAIL %s_model: model gnt=%b, expected %b", nm, exp_gnt, eg);
        end
    endtask

    localparam logic [11:0] W_3111 = {3'd1, 3'd1, 3'd1, 3'd3};
    localparam logic [11:0] W_0701 = {3'd1, 3'd1, 3'd7, 3'd0};

    initial begin
        logic [3:0]  rr_seq [5];
        logic [3:0]  wrr_seq [8];
        logic [1:0]  rmode;
        checks = 0; failures = 0; model_ok = 1'b0;
        rst = 1'b1; bus.req = '0; bus.req_mask = '0; bus.arb_mode = '0;
        bus.prio_top = '0; bus.weights = '0;
        rr_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        wrr_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};

        // Reset state
        apply(1, 4'b1111, 4'b0000, 2'd1, 2'd0, W_3111);
        apply(1, 4'b1111, 4'b0000, 2'd1, 2'd0, W_3111);
        lit("reset", 4'b0000);

        // Fixed priority starting at index 2
        for (int i = 0; i < 3; i++) begin
            apply(0, 4'b1011, 4'b0000, 2'd0, 2'd2, W_3111);
            lit("fixed_top2", 4'b1000);
        end
        apply(0, 4'b1011, 4'b0000, 2'd0, 2'd0, W_3111);
        lit("fixed_top0", 4'b0001);

        // Round-robin from reset
        apply(1, 4'b0000, 4'b0000, 2'd1, 2'd0, W_3111);
        foreach (rr_seq[i]) begin
            apply(0, 4'b1111, 4'b0000, 2'd1, 2'd0, W_3111);
            lit("rr_rotate", rr_seq[i]);
        end
        apply(0, 4'b0000, 4'b0000, 2'd1, 2'd0, W_3111);
        lit("rr_drop_all", 4'b0000);

        // Weighted round-robin, w0=3
        apply(1, 4'b0000, 4'b0000, 2'd2, 2'd0, W_3111);
        foreach (wrr_seq[i]) begin
            apply(0, 4'b0011, 4'b0000, 2'd2, 2'd0, W_3111);
            lit("wrr_weights", wrr_seq[i]);
        end
        apply(0, 4'b0011, 4'b0000, 2'd2, 2'd0, W_3111);
        lit("wrr_owner0", 4'b0001);
        // Owner 0 drops mid-credit: no bubble
        apply(0, 4'b0110, 4'b0000, 2'd2, 2'd0, W_3111);
        lit("wrr_owner_drop", 4'b0010);
        apply(0, 4'b0110, 4'b0000, 2'd2, 2'd0, W_3111);
        lit("wrr_next", 4'b0100);

        // Masked round-robin, then disabled
        apply(0, 4'b1111, 4'b0101, 2'd1, 2'd0, W_3111);
        lit("mask_rr_a", 4'b1000);
        apply(0, 4'b1111, 4'b0101, 2'd1, 2'd0, W_3111);
        lit("mask_rr_b", 4'b0010);
        apply(0, 4'b1111, 4'b0101, 2'd1, 2'd0, W_3111);
        lit("mask_rr_c", 4'b1000);
        apply(0, 4'b1111, 4'b0101, 2'd3, 2'd0, W_3111);
        lit("mode3_off", 4'b0000);

        // Reset in the middle of a WRR burst
        apply(0, 4'b0011, 4'b0000, 2'd2, 2'd0, W_3111);
        lit("burst_start", 4'b0001);
        apply(1, 4'b0011, 4'b0000, 2'd2, 2'd0, W_3111);
        lit("burst_reset", 4'b0000);
        apply(0, 4'b1111, 4'b0000, 2'd1, 2'd0, W_3111);
        lit("post_reset_rr", 4'b0001);
        apply(0, 4'b1111, 4'b0000, 2'd1, 2'd0, W_3111);
        lit("post_reset_rr2", 4'b0010);

        // Zero weight acts as 1; maximum weight gives 7 consecutive grants
        apply(1, 4'b0000, 4'b0000, 2'd2, 2'd0, W_0701);
        apply(0, 4'b0011, 4'b0000, 2'd2, 2'd0, W_0701);
        lit("w_zero", 4'b0001);
        for (int i = 0; i < 7; i++) begin
            apply(0, 4'b0011, 4'b0000, 2'd2, 2'd0, W_0701);
            lit("w_max", 4'b0010);
        end
        apply(0, 4'b0011, 4'b0000, 2'd2, 2'd0, W_0701);
        lit("w_max_release", 4'b0001);

        // Pseudo-random soak, checked by the model every cycle
        rmode = 2'd2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) rmode = 2'($urandom_range(0, 3));
            apply($urandom_range(0, 99) == 0,
                  4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                  rmode,
                  2'($urandom),
                  ($urandom_range(0, 7) == 0) ? 12'($urandom) : W_3111);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
